cfg_shadow_arbiter: RTL

CFG_SHADOW_ARBITER -- requirements
Module: cfg_shadow_arbiter

---
 rtl/cfg_shadow_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cfg_shadow_arbiter.sv
// cfg_shadow_arbiter: shares one single-port shadow BRAM between PCIe config-extension
// accesses and a host port. PCIe pulses are latched into a one-entry pending slot; a small
// FSM (IDLE/ISSUE/RD_WAIT/RESP) serves one access at a time with registered outputs.
// Optional host starvation guard enabled by defining CFG_SHADOW_STARVE_GUARD_EN.
module cfg_shadow_arbiter #(
   parameter int unsigned HOST_STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_ext_read_received,
   input  logic        cfg_ext_write_received,
   input  logic [9:0]  cfg_ext_register_number,
   input  logic [3:0]  cfg_ext_function_number,
   input  logic [31:0] cfg_ext_write_data,
   input  logic [3:0]  cfg_ext_write_byte_enable,
   output logic [31:0] cfg_ext_read_data,
   output logic        cfg_ext_read_data_valid,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [11:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic        host_ack,
   output logic [31:0] host_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   output logic        cfg_overrun
);
   localparam logic [3:0] StarveLimit = 4'(HOST_STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_e;

   state_e      r_state;
   logic        r_pend_valid, r_pend_we;
   logic [9:0]  r_pend_addr;
   logic [3:0]  r_pend_fn;
   logic [31:0] r_pend_data;
   logic [3:0]  r_pend_be;
   logic        r_txn_host, r_txn_we, r_txn_bad;
   logic        r_mem_en, r_mem_we;
   logic [9:0]  r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_be;
   logic [31:0] r_rd_data, r_host_rdata;
   logic        r_rd_valid, r_host_ack, r_overrun;
   logic        w_wr_take, w_rd_take, w_pcie_in, w_drop;
   logic        w_force_host, w_pcie_grant, w_host_grant;
   logic        w_unused;

   // A write beats a simultaneous read; anything arriving on a full slot is lost.
   assign w_wr_take = cfg_ext_write_received & ~r_pend_valid;
   assign w_rd_take = cfg_ext_read_received & ~cfg_ext_write_received & ~r_pend_valid;
   assign w_pcie_in = w_wr_take | w_rd_take;
   assign w_drop    = ((cfg_ext_read_received | cfg_ext_write_received) & r_pend_valid) |
                      (cfg_ext_read_received & cfg_ext_write_received);

`ifdef CFG_SHADOW_STARVE_GUARD_EN
   logic [3:0] r_starve;

   assign w_force_host = host_req & ~r_host_ack & (r_starve >= StarveLimit);

   // Count PCIe grants taken while the host waits; cleared whenever the host is served
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve <= '0;
      end else if (w_host_grant) begin
         r_starve <= '0;
      end else if (w_pcie_grant && host_req && (r_starve < StarveLimit)) begin
         r_starve <= r_starve + 4'd1;
      end
   end

   assign w_unused = ^host_addr[1:0];
`else
   assign w_force_host = 1'b0;
   assign w_unused     = ^{host_addr[1:0], StarveLimit};
`endif

   // A PCIe pulse arriving this edge also blocks the host, so PCIe wins same-cycle contention.
   // The host is not re-granted in its own ack cycle, while it still holds host_req.
   assign w_pcie_grant = (r_state == StIdle) & r_pend_valid & ~w_force_host;
   assign w_host_grant = (r_state == StIdle) & host_req & ~r_host_ack &
                         (w_force_host | (~r_pend_valid & ~w_pcie_in));

   // Pending slot: filled by an accepted pulse, freed when the request is granted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_valid <= 1'b0;
         r_pend_we    <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_fn    <= '0;
         r_pend_data  <= '0;
         r_pend_be    <= '0;
      end else if (w_pcie_in) begin
         r_pend_valid <= 1'b1;
         r_pend_we    <= w_wr_take;
         r_pend_addr  <= cfg_ext_register_number;
         r_pend_fn    <= cfg_ext_function_number;
         r_pend_data  <= cfg_ext_write_data;
         r_pend_be    <= cfg_ext_write_byte_enable;
      end else if (w_pcie_grant) begin
         r_pend_valid <= 1'b0;
      end
   end

   // Sticky overrun flag for any dropped PCIe pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end
   end

   // Access FSM with registered memory bus and response strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= StIdle;
         r_txn_host   <= 1'b0;
         r_txn_we     <= 1'b0;
         r_txn_bad    <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_be     <= '0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
         r_host_rdata <= '0;
         r_host_ack   <= 1'b0;
      end else begin
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_host_ack <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_pcie_grant) begin
                  // Non-zero functions walk the FSM but never touch memory
                  r_state     <= StIssue;
                  r_txn_host  <= 1'b0;
                  r_txn_we    <= r_pend_we;
                  r_txn_bad   <= (r_pend_fn != 4'd0);
                  r_mem_en    <= (r_pend_fn == 4'd0);
                  r_mem_we    <= r_pend_we & (r_pend_fn == 4'd0);
                  r_mem_addr  <= r_pend_addr;
                  r_mem_wdata <= r_pend_data;
                  r_mem_be    <= r_pend_be;
               end else if (w_host_grant) begin
                  r_state     <= StIssue;
                  r_txn_host  <= 1'b1;
                  r_txn_we    <= host_we;
                  r_txn_bad   <= 1'b0;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= host_we;
                  r_mem_addr  <= host_addr[11:2];
                  r_mem_wdata <= host_wdata;
                  r_mem_be    <= 4'hF;
               end
            end
            StIssue: begin
               if (r_txn_we) begin
                  r_state    <= StIdle;
                  r_host_ack <= r_txn_host;
               end else begin
                  r_state <= StRdWait;
               end
            end
            StRdWait: begin
               r_state <= StResp;
               if (r_txn_host) begin
                  r_host_ack   <= 1'b1;
                  r_host_rdata <= mem_rdata;
               end else begin
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= r_txn_bad ? 32'hFFFF_FFFF : mem_rdata;
               end
            end
            StResp: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign cfg_ext_read_data       = r_rd_data;
   assign cfg_ext_read_data_valid = r_rd_valid;
   assign host_ack                = r_host_ack;
   assign host_rdata              = r_host_rdata;
   assign mem_en                  = r_mem_en;
   assign mem_we                  = r_mem_we;
   assign mem_addr                = r_mem_addr;
   assign mem_wdata               = r_mem_wdata;
   assign mem_be                  = r_mem_be;
   assign cfg_overrun             = r_overrun;

endmodule
